// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: decode for the 16-bit ISA with 8-entry regfile,
// write-through bypass, load-use stall, flush and sticky illegal flag.
// Ports: clk, rst (async, active-low); fetch side in_valid/in_ready,
//   instr, pc_in, flush; writeback wb_en/wb_reg/wb_data; ID/EX side
//   out_valid/out_ready, out_rs/rt/imm/wreg/alu_op/pc, control flags, err.
module decode_stage_pipe #(
  parameter int DATA_W     = 16,
  parameter bit RF_BYPASS  = 1'b1,
  parameter bit LOAD_STALL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs,
  output logic [DATA_W-1:0] out_rt,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_wreg,
  output logic [2:0]        out_alu_op,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_reg_wr,
  output logic              out_br_ju,
  output logic [DATA_W-1:0] out_pc,
  output logic              err
);

  logic [DATA_W-1:0] r_rf [8];

  logic [4:0]        w_op;
  logic              w_is_r, w_is_i, w_is_jl, w_ill;
  logic              w_mem, w_immop;
  logic              w_s5, w_z5, w_s8, w_s11;
  logic              w_mrd, w_mwr, w_rwr, w_br, w_rd_rt;
  logic [2:0]        w_dest, w_alu;
  logic [DATA_W-1:0] w_imm, w_rs, w_rt;
  logic              w_stall, w_accept;

  assign w_op    = instr[15:11];
  assign w_is_r  = (w_op[4:1] == 4'b1101) | (w_op[4:2] == 3'b111);
  assign w_is_i  = (w_op[4:2] == 3'b010) | (w_op[4:2] == 3'b101)
                 | (w_op[4:2] == 3'b100);
  assign w_is_jl = (w_op[4:1] == 4'b0011);
  assign w_ill   = (w_op[4:1] == 4'b0001);
  assign w_mem   = (w_op[4:2] == 3'b100);
  assign w_immop = (w_op[4:2] == 3'b010) | (w_op[4:2] == 3'b011)
                 | (w_op[4:2] == 3'b101);

  assign w_s5  = (w_op[4:1] == 4'b0100) | w_mem;
  assign w_z5  = (w_op[4:1] == 4'b0101) | (w_op[4:2] == 3'b101);
  assign w_s8  = (w_op[4:2] == 3'b011) | (w_op == 5'b11000)
               | ((w_op[4:2] == 3'b001) & w_op[0]);
  assign w_s11 = (w_op[4:2] == 3'b001) & ~w_op[0];

  // odd 100xx are stores: they read rt as data and write no register
  assign w_mrd   = w_mem & ~w_op[0];
  assign w_mwr   = w_mem & w_op[0];
  assign w_rwr   = w_is_r | (w_is_i & ~w_mwr)
                 | (w_op[4:2] == 3'b011) | w_is_jl;
  assign w_br    = (w_op[4:2] == 3'b001) | (w_op == 5'b11000);
  assign w_rd_rt = w_is_r | w_mwr;

  always_comb begin
    w_dest = instr[10:8];
    unique case (1'b1)
      w_is_r:  w_dest = instr[4:2];
      w_is_i:  w_dest = instr[7:5];
      w_is_jl: w_dest = 3'd7;
      default: ;
    endcase
  end

  always_comb begin
    w_imm = '0;
    unique case (1'b1)
      w_s5:    w_imm = {{(DATA_W-5){instr[4]}}, instr[4:0]};
      w_z5:    w_imm = {{(DATA_W-5){1'b0}}, instr[4:0]};
      w_s8:    w_imm = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      w_s11:   w_imm = {{(DATA_W-11){instr[10]}}, instr[10:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_alu = '0;
    unique case (1'b1)
      w_is_r:  w_alu = {1'b0, w_op[1:0]};
      w_mem:   w_alu = 3'b100;
      w_immop: w_alu = {1'b1, w_op[1:0]};
      default: ;
    endcase
  end

  assign w_rs = (RF_BYPASS && wb_en && wb_reg == instr[10:8])
              ? wb_data : r_rf[instr[10:8]];
  assign w_rt = (RF_BYPASS && wb_en && wb_reg == instr[7:5])
              ? wb_data : r_rf[instr[7:5]];

  // a load in ID/EX has no data until after execute; hold its consumer
  assign w_stall = LOAD_STALL & out_valid & out_mem_rd & out_reg_wr
                 & ((out_wreg == instr[10:8])
                 | ((out_wreg == instr[7:5]) & w_rd_rt));

  assign in_ready = rst & ~flush & ~w_stall & (~out_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) r_rf[i] <= '0;
    end else if (wb_en) begin
      r_rf[wb_reg] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_rs     <= '0;
      out_rt     <= '0;
      out_imm    <= '0;
      out_wreg   <= '0;
      out_alu_op <= '0;
      out_mem_rd <= 1'b0;
      out_mem_wr <= 1'b0;
      out_reg_wr <= 1'b0;
      out_br_ju  <= 1'b0;
      out_pc     <= '0;
      err        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid  <= 1'b1;
      out_rs     <= w_rs;
      out_rt     <= w_rt;
      out_imm    <= w_imm;
      out_wreg   <= w_dest;
      out_alu_op <= w_alu;
      out_mem_rd <= w_mrd;
      out_mem_wr <= w_mwr;
      out_reg_wr <= w_rwr;
      out_br_ju  <= w_br;
      out_pc     <= pc_in;
      err        <= err | w_ill;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed and randomized checks of decode_stage_pipe
// against a cycle-level behavioural model of the decode stage.
module tb_decode_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, wb_en, out_ready;
  logic [15:0] instr;
  logic [31:0] pc, wbd;
  logic [2:0]  wb_reg;

  logic        a_in_ready, a_out_valid, a_err;
  logic [15:0] a_rs, a_rt, a_imm, a_pc;
  logic [2:0]  a_wreg, a_alu;
  logic        a_mrd, a_mwr, a_rwr, a_br;

  logic        b_in_ready, b_out_valid, b_err;
  logic [31:0] b_rs, b_rt, b_imm, b_pc;
  logic [2:0]  b_wreg, b_alu;
  logic        b_mrd, b_mwr, b_rwr, b_br;

  always #5 clk = ~clk;

  decode_stage_pipe u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .pc_in(pc[15:0]), .flush(flush), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wbd[15:0]), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_rs(a_rs), .out_rt(a_rt),
    .out_imm(a_imm), .out_wreg(a_wreg), .out_alu_op(a_alu),
    .out_mem_rd(a_mrd), .out_mem_wr(a_mwr), .out_reg_wr(a_rwr),
    .out_br_ju(a_br), .out_pc(a_pc), .err(a_err)
  );

  decode_stage_pipe #(.DATA_W(32), .RF_BYPASS(1'b0), .LOAD_STALL(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .pc_in(pc), .flush(flush), .wb_en(wb_en),
    .wb_reg(wb_reg), .wb_data(wbd), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_rs(b_rs), .out_rt(b_rt),
    .out_imm(b_imm), .out_wreg(b_wreg), .out_alu_op(b_alu),
    .out_mem_rd(b_mrd), .out_mem_wr(b_mwr), .out_reg_wr(b_rwr),
    .out_br_ju(b_br), .out_pc(b_pc), .err(b_err)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] rs, rt, imm, pc;
    logic [2:0]  wreg, alu;
    logic        mrd, mwr, rwr, br;
  } idex_t;

  idex_t       m;
  logic        m_err;
  logic [15:0] m_rf [8];
  int          checks = 0;
  int          passed = 0;

  function automatic logic [15:0] mk_add(input int rs, input int rt,
                                         input int rd);
    mk_add = {5'b11100, 3'(rs), 3'(rt), 3'(rd), 2'b00};
  endfunction

  function automatic logic reads_rt(input logic [15:0] ins);
    int op;
    op = int'(ins[15:11]);
    reads_rt = op inside {[26:31], 17, 19};
  endfunction

  function automatic logic [15:0] rd_reg(input logic [2:0] idx);
    rd_reg = (wb_en && wb_reg == idx) ? wbd[15:0] : m_rf[idx];
  endfunction

  function automatic idex_t model_dec(input logic [15:0] ins,
                                      input logic [15:0] p);
    idex_t d;
    int op, v;
    logic isr, isi;
    op  = int'(ins[15:11]);
    isr = op inside {[26:31]};
    isi = op inside {[8:11], [16:23]};
    d.v  = 1'b1;
    d.pc = p;
    d.rs = rd_reg(ins[10:8]);
    d.rt = rd_reg(ins[7:5]);
    d.wreg = isr ? ins[4:2] : isi ? ins[7:5]
           : (op inside {6, 7}) ? 3'd7 : ins[10:8];
    v = 0;
    if (op inside {8, 9, [16:19]})
      v = int'(ins[4:0]) - (ins[4] ? 32 : 0);
    else if (op inside {10, 11, [20:23]})
      v = int'(ins[4:0]);
    else if (op inside {[12:15], 24, 5, 7})
      v = int'(ins[7:0]) - (ins[7] ? 256 : 0);
    else if (op inside {4, 6})
      v = int'(ins[10:0]) - (ins[10] ? 2048 : 0);
    d.imm = 16'(v);
    d.mrd = op inside {16, 18};
    d.mwr = op inside {17, 19};
    d.rwr = isr || (op inside {[8:16], 18, [20:23], 6, 7});
    d.br  = op inside {[4:7], 24};
    if (isr) d.alu = 3'(op % 4);
    else if (op inside {[8:15], [20:23]}) d.alu = 3'(4 + op % 4);
    else if (op inside {[16:19]}) d.alu = 3'd4;
    else d.alu = 3'd0;
    model_dec = d;
  endfunction

  function automatic logic model_ready();
    logic stall;
    stall = m.v && m.mrd && m.rwr &&
            (m.wreg == instr[10:8] ||
             (m.wreg == instr[7:5] && reads_rt(instr)));
    model_ready = rst && !flush && !stall && (!m.v || out_ready);
  endfunction

  task automatic tick();
    idex_t nx;
    logic acc;
    nx  = m;
    acc = in_valid && model_ready();
    if (!rst) nx = '0;
    else if (flush) nx.v = 1'b0;
    else if (acc) nx = model_dec(instr, pc[15:0]);
    else if (m.v && out_ready) nx.v = 1'b0;
    @(posedge clk);
    if (!rst) begin
      m_err = 1'b0;
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
    end else begin
      if (acc && instr[15:12] == 4'b0001) m_err = 1'b1;
      if (wb_en) m_rf[wb_reg] = wbd[15:0];
    end
    m = nx;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    wb_en     = 1'b0;
    wb_reg    = '0;
    wbd       = '0;
    out_ready = 1'b1;
    instr     = '0;
    pc        = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0)
      $display("FAIL reset_valid: got %b/%b want 0", a_out_valid, b_out_valid);
    else passed++;
    checks++;
    if (a_err !== 1'b0 || b_err !== 1'b0)
      $display("FAIL reset_err: got %b/%b want 0", a_err, b_err);
    else passed++;
    checks++;
    if (a_in_ready !== 1'b0)
      $display("FAIL reset_in_ready: got %b want 0", a_in_ready);
    else passed++;
    checks++;
    if ({a_rs, a_rt, a_imm, a_pc, a_wreg, a_alu,
         a_mrd, a_mwr, a_rwr, a_br} !== '0)
      $display("FAIL reset_fields: got rs=%h rt=%h imm=%h pc=%h want 0",
               a_rs, a_rt, a_imm, a_pc);
    else passed++;
    idle();
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      instr    = mk_add(i, 7 - i, 0);
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_rs !== 16'h0 || a_rt !== 16'h0 ||
          b_rs !== 32'h0 || b_rt !== 32'h0)
        $display("FAIL reset_rf_r%0d: got v=%b rs=%h rt=%h b_rs=%h want v=1 all 0",
                 i, a_out_valid, a_rs, a_rt, b_rs);
      else passed++;
    end
    idle();
    tick();
  endtask

  task automatic test_bypass();
    in_valid = 1'b1;
    instr    = mk_add(3, 3, 1);
    wb_en    = 1'b1;
    wb_reg   = 3'd3;
    wbd      = 32'h0000BEEF;
    tick();
    checks++;
    if (a_rs !== 16'hBEEF || a_rt !== 16'hBEEF)
      $display("FAIL bypass_on: got rs=%h rt=%h want beef", a_rs, a_rt);
    else passed++;
    checks++;
    if (b_rs !== 32'h0 || b_rt !== 32'h0)
      $display("FAIL bypass_off: got rs=%h rt=%h want 0", b_rs, b_rt);
    else passed++;
    wb_en = 1'b0;
    instr = mk_add(3, 0, 2);
    tick();
    checks++;
    if (a_rs !== 16'hBEEF || b_rs !== 32'h0000BEEF)
      $display("FAIL bypass_written: got %h/%h want beef", a_rs, b_rs);
    else passed++;
    idle();
    tick();
  endtask

  task automatic test_load_use();
    in_valid = 1'b1;
    instr    = {5'b10000, 3'd0, 3'd2, 5'd4};
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_mrd !== 1'b1 || a_wreg !== 3'd2 ||
        a_imm !== 16'h0004)
      $display("FAIL ld_issue: got v=%b mrd=%b wreg=%0d imm=%h want 1 1 2 0004",
               a_out_valid, a_mrd, a_wreg, a_imm);
    else passed++;
    instr = mk_add(2, 1, 5);
    #1;
    checks++;
    if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0)
      $display("FAIL ld_stall: got in_ready=%b/%b want 0", a_in_ready, b_in_ready);
    else passed++;
    tick();
    checks++;
    if (a_out_valid !== 1'b0)
      $display("FAIL ld_bubble: got out_valid=%b want 0", a_out_valid);
    else passed++;
    checks++;
    if (a_in_ready !== 1'b1)
      $display("FAIL ld_release: got in_ready=%b want 1", a_in_ready);
    else passed++;
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_wreg !== 3'd5 || a_mrd !== 1'b0)
      $display("FAIL ld_consumer: got v=%b wreg=%0d mrd=%b want 1 5 0",
               a_out_valid, a_wreg, a_mrd);
    else passed++;
    instr = {5'b10000, 3'd0, 3'd2, 5'd0};
    tick();
    instr = {5'b01000, 3'd1, 3'd2, 5'd1};
    #1;
    checks++;
    if (a_in_ready !== 1'b1)
      $display("FAIL ld_no_rt_read: got in_ready=%b want 1", a_in_ready);
    else passed++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1;
    instr    = mk_add(1, 2, 1);
    pc       = 32'h1234;
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_pc !== 16'h1234)
      $display("FAIL bp_first: got v=%b pc=%h want 1 1234", a_out_valid, a_pc);
    else passed++;
    out_ready = 1'b0;
    instr     = mk_add(4, 5, 6);
    pc        = 32'h5678;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (a_in_ready !== 1'b0)
        $display("FAIL bp_ready_%0d: got %b want 0", i, a_in_ready);
      else passed++;
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_pc !== 16'h1234 || a_wreg !== 3'd1)
        $display("FAIL bp_hold_%0d: got v=%b pc=%h wreg=%0d want 1 1234 1",
                 i, a_out_valid, a_pc, a_wreg);
      else passed++;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1)
      $display("FAIL bp_drain_ready: got %b want 1", a_in_ready);
    else passed++;
    tick();
    checks++;
    if (a_out_valid !== 1'b1 || a_pc !== 16'h5678 || a_wreg !== 3'd6)
      $display("FAIL bp_next: got v=%b pc=%h wreg=%0d want 1 5678 6",
               a_out_valid, a_pc, a_wreg);
    else passed++;
    idle();
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    instr    = mk_add(0, 0, 3);
    tick();
    flush  = 1'b1;
    instr  = {5'b00010, 11'h123};
    wb_en  = 1'b1;
    wb_reg = 3'd6;
    wbd    = 32'h00005A5A;
    #1;
    checks++;
    if (a_in_ready !== 1'b0)
      $display("FAIL flush_ready: got %b want 0", a_in_ready);
    else passed++;
    tick();
    checks++;
    if (a_out_valid !== 1'b0 || a_err !== 1'b0)
      $display("FAIL flush_squash: got v=%b err=%b want 0 0", a_out_valid, a_err);
    else passed++;
    flush = 1'b0;
    wb_en = 1'b0;
    instr = mk_add(6, 6, 0);
    tick();
    checks++;
    if (a_rs !== 16'h5A5A || b_rs !== 32'h5A5A)
      $display("FAIL flush_wb: got %h/%h want 5a5a", a_rs, b_rs);
    else passed++;
    idle();
    tick();
  endtask

  task automatic test_illegal();
    in_valid = 1'b1;
    instr    = {5'b00010, 11'h5A5};
    tick();
    checks++;
    if (a_err !== 1'b1 || b_err !== 1'b1 || a_out_valid !== 1'b1)
      $display("FAIL ill_set: got err=%b/%b v=%b want 1", a_err, b_err, a_out_valid);
    else passed++;
    checks++;
    if ({a_mrd, a_mwr, a_rwr, a_br} !== 4'b0 || a_imm !== 16'h0)
      $display("FAIL ill_flags: got flags=%b imm=%h want 0",
               {a_mrd, a_mwr, a_rwr, a_br}, a_imm);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(4, 31));
      instr = {op, 11'($urandom)};
      tick();
      checks++;
      if (a_err !== 1'b1)
        $display("FAIL ill_sticky_%0d: got %b want 1", i, a_err);
      else passed++;
    end
    idle();
    tick();
    tick();
    in_valid = 1'b1;
    instr    = {5'b00100, 11'h7FF};
    tick();
    checks++;
    if (b_imm !== 32'hFFFFFFFF || a_imm !== 16'hFFFF || a_br !== 1'b1)
      $display("FAIL j_imm_neg: got %h/%h br=%b want ffffffff", b_imm, a_imm, a_br);
    else passed++;
    instr = {5'b00100, 11'h3FF};
    tick();
    checks++;
    if (b_imm !== 32'h000003FF)
      $display("FAIL j_imm_pos: got %h want 000003ff", b_imm);
    else passed++;
    instr = {5'b00110, 11'h400};
    tick();
    checks++;
    if (b_imm !== 32'hFFFFFC00 || a_wreg !== 3'd7 || a_rwr !== 1'b1)
      $display("FAIL jal: got imm=%h wreg=%0d rwr=%b want fffffc00 7 1",
               b_imm, a_wreg, a_rwr);
    else passed++;
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:11] = 5'b10000;
      ins[10:8] = 3'($urandom_range(0, 3));
      ins[7:5]  = 3'($urandom_range(0, 3));
      instr     = ins;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      wb_en     = $urandom_range(0, 1) != 0;
      wb_reg    = 3'($urandom_range(0, 7));
      wbd       = 32'($urandom);
      pc        = 32'($urandom);
      #1;
      checks++;
      if (a_in_ready !== model_ready())
        $display("FAIL rnd_ready @%0d: got %b want %b", n, a_in_ready, model_ready());
      else passed++;
      tick();
      checks++;
      if (a_out_valid !== m.v || a_err !== m_err)
        $display("FAIL rnd_valid @%0d: got v=%b err=%b want v=%b err=%b",
                 n, a_out_valid, a_err, m.v, m_err);
      else passed++;
      if (m.v) begin
        checks++;
        if ({a_rs, a_rt, a_imm, a_pc, a_wreg, a_alu, a_mrd, a_mwr, a_rwr,
             a_br} !== {m.rs, m.rt, m.imm, m.pc, m.wreg, m.alu, m.mrd,
             m.mwr, m.rwr, m.br})
          $display("FAIL rnd_fields @%0d: got rs=%h rt=%h imm=%h pc=%h wreg=%0d alu=%0d f=%b want rs=%h rt=%h imm=%h pc=%h wreg=%0d alu=%0d f=%b",
                   n, a_rs, a_rt, a_imm, a_pc, a_wreg, a_alu,
                   {a_mrd, a_mwr, a_rwr, a_br}, m.rs, m.rt, m.imm, m.pc,
                   m.wreg, m.alu, {m.mrd, m.mwr, m.rwr, m.br});
        else passed++;
      end
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    wb_en    = 1'b1;
    wb_reg   = 3'd5;
    wbd      = 32'h1234;
    in_valid = 1'b1;
    instr    = mk_add(1, 1, 1);
    tick();
    wb_en     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_err !== 1'b1)
      $display("FAIL mid_pre: got v=%b err=%b want 1 1", a_out_valid, a_err);
    else passed++;
    test_reset();
  endtask

  initial begin
    m     = '0;
    m_err = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    idle();
    rst = 1'b1;
    #1;
    test_reset();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
